// File: rtl/mb_pc_sequencer_pkg.sv
// Shared definitions for the math-box program sequencer (package mb_seq_pkg).
// Holds the sequencer state encoding and the default widths.
package mb_seq_pkg;

  // Sequencer states: IDLE waits for a start strobe, RUN steps the ROM address.
  typedef enum logic {
    MB_IDLE = 1'b0,
    MB_RUN  = 1'b1
  } mb_state_e;

  // Default program counter width (multiple of 4: CPU writes it as nibbles).
  localparam int MB_PC_W        = 8;
  // Default return-address stack depth and matching pointer width.
  localparam int MB_STACK_DEPTH = 4;
  localparam int MB_SP_W        = 2;

endpackage

// File: rtl/mb_pc_sequencer_if.sv
// Bus between the CPU/microcode side and the program sequencer.
// master: drives start strobe and microcode control, observes PC/status.
// slave:  the sequencer itself.
interface mb_pc_sequencer_if
  import mb_seq_pkg::*;
#(
  parameter int PC_W = MB_PC_W
);
  logic            LDAB;
  logic [PC_W-1:0] Addr_In;
  logic            Halt_In;
  logic            Jmp_In;
  logic            Cond_In;
  logic            Call_In;
  logic            Ret_In;
  logic [PC_W-1:0] Jmp_Addr;
  logic [PC_W-1:0] PC;
  logic            Running;
  logic            Done;
  logic            Stack_Err;

  modport master (
    output LDAB, Addr_In, Halt_In, Jmp_In, Cond_In, Call_In, Ret_In, Jmp_Addr,
    input  PC, Running, Done, Stack_Err
  );

  modport slave (
    input  LDAB, Addr_In, Halt_In, Jmp_In, Cond_In, Call_In, Ret_In, Jmp_Addr,
    output PC, Running, Done, Stack_Err
  );
endinterface

// File: rtl/mb_pc_sequencer_ret_stack.sv
// Return-address LIFO for the program sequencer (module mb_ret_stack).
// Push on full and pop on empty are ignored; the caller flags those as errors.
// The occupancy counter is one bit wider than SP_W so "full" (== DEPTH) is
// representable alongside "empty" (== 0).
module mb_ret_stack
  import mb_seq_pkg::*;
#(
  parameter int PC_W  = MB_PC_W,
  parameter int DEPTH = MB_STACK_DEPTH,
  parameter int SP_W  = MB_SP_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic            full,
  output logic            empty
);
  localparam int CNT_W = SP_W + 1;

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [PC_W-1:0]  mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign top_data = mem_q[SP_W'(cnt_q - CNT_W'(1))];

  // Next-state: clear wins, then a guarded push, then a guarded pop.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (push && !full) begin
      mem_d[cnt_q[SP_W-1:0]] = push_data;
      cnt_d                  = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Stack storage and pointer; reset clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/mb_pc_sequencer.sv
// Math-box program sequencer: loads a start address on LDAB, then produces one
// microcode ROM address per clock with conditional jump, call/return through
// mb_ret_stack, and halt. PC, Running, Done and Stack_Err are all registered.
// Optional build macro MB_SEQ_ERR_HALT_EN: a stack over/underflow also stops
// the sequencer (RUN->IDLE, Done pulse, PC held) instead of only flagging it.
module mb_pc_sequencer
  import mb_seq_pkg::*;
#(
  parameter int PC_W        = MB_PC_W,
  parameter int STACK_DEPTH = MB_STACK_DEPTH,
  parameter int SP_W        = MB_SP_W
) (
  input  logic              CLK,
  input  logic              Begin,
  mb_pc_sequencer_if.slave  bus
);
  mb_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] stk_top;
  logic            stk_push, stk_pop, stk_clr;
  logic            stk_full, stk_empty;

  // Sequential address wraps modulo 2^PC_W; the pushed return address too.
  assign pc_inc = pc_q + PC_W'(1);

  mb_ret_stack #(
    .PC_W  (PC_W),
    .DEPTH (STACK_DEPTH),
    .SP_W  (SP_W)
  ) u_stack (
    .clk       (CLK),
    .rst       (Begin),
    .push      (stk_push),
    .pop       (stk_pop),
    .clear     (stk_clr),
    .push_data (pc_inc),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Next-address mux and state decisions; LDAB restarts from any state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    done_d   = 1'b0;
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
    if (bus.LDAB) begin
      state_d = MB_RUN;
      pc_d    = bus.Addr_In;
      stk_clr = 1'b1;
    end else if (state_q == MB_RUN) begin
      if (bus.Halt_In) begin
        state_d = MB_IDLE;
        done_d  = 1'b1;
      end else if (bus.Ret_In) begin
        if (!stk_empty) begin
          stk_pop = 1'b1;
          pc_d    = stk_top;
        end else begin
          err_d = 1'b1;
`ifdef MB_SEQ_ERR_HALT_EN
          state_d = MB_IDLE;
          done_d  = 1'b1;
`else
          pc_d    = pc_inc;
`endif
        end
      end else if (bus.Call_In) begin
        if (!stk_full) begin
          stk_push = 1'b1;
          pc_d     = bus.Jmp_Addr;
        end else begin
          err_d = 1'b1;
`ifdef MB_SEQ_ERR_HALT_EN
          state_d = MB_IDLE;
          done_d  = 1'b1;
`else
          pc_d    = bus.Jmp_Addr;
`endif
        end
      end else if (bus.Jmp_In && bus.Cond_In) begin
        pc_d = bus.Jmp_Addr;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // FSM with registered PC, Done pulse and sticky stack error.
  always_ff @(posedge CLK or posedge Begin) begin
    if (Begin) begin
      state_q <= MB_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.PC        = pc_q;
  assign bus.Running   = (state_q == MB_RUN);
  assign bus.Done      = done_q;
  assign bus.Stack_Err = err_q;
endmodule

// File: doc/mb_pc_sequencer.md
Name: mb_pc_sequencer

Overview:
Parametrised math-box program sequencer. It generalises the plain start-address latch into a running program counter. It loads a start address on LDAB, then steps through microcode ROM addresses each clock, with conditional jump, call/return on a parametrised stack, and a halt. It sits between the CPU-side start-address write and the math-box microcode ROM address input.

Parameters:
PC_W, 8, program counter / ROM address width (multiple of 4).
STACK_DEPTH, 4, return-address stack entries (>=1).
SP_W, 2, stack pointer width; clog2(STACK_DEPTH), minimum 1.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
Begin  input  1  reset, asynchronous, active-high.
LDAB  input  1  start strobe; load Addr_In and run.
Addr_In  input  PC_W  start address (CPU-side nibbles concatenated).
Halt_In  input  1  microcode STOP bit for current PC.
Jmp_In  input  1  microcode jump request.
Cond_In  input  1  jump condition (ALU flag select, already resolved).
Call_In  input  1  microcode subroutine call.
Ret_In  input  1  microcode return.
Jmp_Addr  input  PC_W  jump/call target from microcode.
PC  output  PC_W  current ROM address.
Running  output  1  sequencer in RUN state.
Done  output  1  one-cycle pulse on RUN->IDLE.
Stack_Err  output  1  sticky over/underflow flag.

Behaviour:
- Clocking and reset: one clock; reset asynchronous, active-high. Begin forces PC=0, SP=0, all stack entries 0, state IDLE, Running=0, Done=0, Stack_Err=0. Begin overrides every other input.
- States: IDLE, RUN. Running=1 exactly in RUN.
- IDLE:
  - LDAB=1 -> PC<=Addr_In, SP<=0, state RUN next cycle.
  - Otherwise PC holds.
  - Microcode inputs are ignored.
- RUN, with LDAB=0. Priority per cycle:
  1. Halt_In -> state IDLE, PC holds, Done=1 for one cycle.
  2. Ret_In -> if SP>0: PC<=stack[SP-1], SP<=SP-1. If SP=0 (underflow): PC<=PC+1, Stack_Err<=1.
  3. Call_In -> if SP<STACK_DEPTH: stack[SP]<=PC+1, SP<=SP+1, PC<=Jmp_Addr. If full (overflow): PC<=Jmp_Addr, push dropped, Stack_Err<=1.
  4. Jmp_In & Cond_In -> PC<=Jmp_Addr.
  5. Otherwise -> PC<=PC+1.
  - Jmp_In with Cond_In=0 is treated as increment.
- RUN, with LDAB=1: restart. PC<=Addr_In, SP<=0, stay RUN, no Done pulse. LDAB beats Halt_In in the same cycle.
- Latency: each control input takes effect on PC at the next rising edge (one-cycle next-address latency). PC is a registered output.
- Width rules:
  - PC+1 is modulo 2^PC_W: all-ones wraps to 0, no flag.
  - Return address PC+1 wraps identically.
- Stack_Err is cleared only by Begin.
- Done is low in all cycles except the RUN->IDLE transition cycle.

Optional Feature:
Macro MB_SEQ_ERR_HALT_EN.
- Defined: any cycle that sets Stack_Err (over/underflow) also forces RUN->IDLE with a Done pulse, and PC holds.
- Undefined: execution continues as described in Behaviour; the error is only flagged.

Decomposition:
Shared package mb_seq_pkg holds:
- state enum (MB_IDLE=0, MB_RUN=1);
- default widths MB_PC_W=8, MB_STACK_DEPTH=4.

One sub-module is natural: mb_ret_stack. It is a LIFO with push/pop/clear, full/empty flags, and async Begin clear. The top block keeps the FSM and next-PC mux.

Test Plan:
1. Reset and start: Begin pulse -> PC=0, Running=0. Then LDAB with Addr_In=0x10 -> next cycle PC=0x10, Running=1; the next 3 cycles give 0x11, 0x12, 0x13.
2. Jump: at PC=0x20, Jmp_In=1, Cond_In=1, Jmp_Addr=0x40 -> PC=0x40. Repeat with Cond_In=0 -> PC=0x21.
3. Call and return: at PC=0x30, Call to 0x80 -> PC=0x80. Increment to 0x81, then Ret -> PC=0x31, SP back to 0.
4. Overflow: 5 nested calls with STACK_DEPTH=4 -> the 5th sets Stack_Err=1, PC=target.
   - Without the macro: running continues.
   - With MB_SEQ_ERR_HALT_EN: Running=0 and Done pulses.
5. Underflow: Ret at SP=0 at PC=0xFF -> PC=0x00 (wrap), Stack_Err=1.
6. Halt and restart:
   - Halt_In at PC=0x55 -> Done=1 for one cycle, Running=0, PC stays 0x55.
   - LDAB with Addr_In=0x02 -> RUN with PC=0x02.
   - Begin asserted mid-RUN between clock edges -> PC=0 immediately.
